// File: rtl/spi_slave_regs.sv
// SPI mode-0 slave (MSB first) behind a small register file: rxdata, txdata, status, control.
// SCLK/MOSI/SS_n are oversampled in the clk domain; f_SCLK must stay at or below f_clk/8.
module spi_slave_regs #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_from_cpu,
  input  logic [2:0]            mem_addr,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic                  spi_select,
  output logic [DATA_WIDTH-1:0] data_to_cpu,
  output logic                  dataavailable,
  output logic                  readyfordata,
  output logic                  transmitterempty,
  output logic                  irq,
  input  logic                  SCLK,
  input  logic                  MOSI,
  input  logic                  SS_n,
  output logic                  MISO
);
  localparam int DW = DATA_WIDTH;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
  state_t state_reg, state_next;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_prev, ss_prev;
  logic [DW-1:0]          rxdata_reg, txdata_reg, shift_rx_reg, shift_tx_reg, data_out_reg;
  logic [CW-1:0]          bitcnt_reg;
  logic [5:0]             ctrl_reg;
  logic                   rrdy_reg, trdy_reg, toe_reg, roe_reg, miso_reg, irq_reg;
  logic                   frame_start;

  // Synchronizers carry no reset so a held-low SS_n across reset never looks like a fresh fall.
  always_ff @(posedge clk) begin
    sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
    mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
    ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_n};
    sclk_prev <= sclk_sync[SYNC_STAGES-1];
    ss_prev   <= ss_sync[SYNC_STAGES-1];
  end

  logic sclk_s, mosi_s, ss_s, sclk_rise, sclk_fall, ss_fall, ss_rise;
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev;
  assign sclk_fall = ~sclk_s & sclk_prev;
  assign ss_fall   = ss_prev & ~ss_s;
  assign ss_rise   = ss_s & ~ss_prev;

  logic rd_en, wr_en, rx_read, tmt, err_any, frame_full;
  assign rd_en      = spi_select & ~read_n;
  assign wr_en      = spi_select & ~write_n;
  assign rx_read    = rd_en && (mem_addr == 3'd0);
  assign tmt        = (state_reg == IDLE) && trdy_reg;
  assign err_any    = roe_reg | toe_reg;
  assign frame_full = (bitcnt_reg == CW'(DW));

  logic [DW-1:0] status_word, ctrl_word;
  always_comb begin
    status_word      = '0;
    status_word[8:0] = {err_any, rrdy_reg, trdy_reg, tmt, toe_reg, roe_reg, 3'b000};
    ctrl_word        = '0;
    ctrl_word[8:0]   = {ctrl_reg, 3'b000};
  end

  always_comb begin
    state_next  = state_reg;
    frame_start = 1'b0;
    case (state_reg)
      IDLE: begin
        if (ss_fall) begin
          state_next  = ACTIVE;
          frame_start = 1'b1;
        end
      end
      ACTIVE: begin
        if (frame_full)   state_next = DONE;
        else if (ss_rise) state_next = IDLE;
      end
      DONE: begin
        if (!ss_s) begin
          state_next  = ACTIVE;
          frame_start = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      rxdata_reg   <= '0;
      txdata_reg   <= '0;
      shift_rx_reg <= '0;
      shift_tx_reg <= '0;
      data_out_reg <= '0;
      bitcnt_reg   <= '0;
      ctrl_reg     <= '0;
      rrdy_reg     <= 1'b0;
      trdy_reg     <= 1'b1;
      toe_reg      <= 1'b0;
      roe_reg      <= 1'b0;
      miso_reg     <= 1'b0;
      irq_reg      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (rd_en) begin
        case (mem_addr)
          3'd0:    data_out_reg <= rxdata_reg;
          3'd1:    data_out_reg <= txdata_reg;
          3'd2:    data_out_reg <= status_word;
          3'd3:    data_out_reg <= ctrl_word;
          default: data_out_reg <= '0;
        endcase
      end
      if (rx_read) rrdy_reg <= 1'b0;
      // Flag clears come before the frame engine so a same-cycle error event wins.
      if (wr_en && mem_addr == 3'd2) begin
        roe_reg <= 1'b0;
        toe_reg <= 1'b0;
      end
      if (wr_en && mem_addr == 3'd3) ctrl_reg <= data_from_cpu[8:3];

      case (state_reg)
        IDLE: miso_reg <= 1'b0;
        ACTIVE: begin
          if (!frame_full) begin
            if (ss_rise) begin
              bitcnt_reg <= '0;
              miso_reg   <= 1'b0;
            end else if (sclk_rise) begin
              shift_rx_reg <= {shift_rx_reg[DW-2:0], mosi_s};
              bitcnt_reg   <= bitcnt_reg + CW'(1);
            end else if (sclk_fall && bitcnt_reg != '0) begin
              shift_tx_reg <= {shift_tx_reg[DW-2:0], 1'b0};
              miso_reg     <= shift_tx_reg[DW-2];
            end
          end
        end
        DONE: begin
          rxdata_reg <= shift_rx_reg;
          rrdy_reg   <= 1'b1;
          if (rrdy_reg && !rx_read) roe_reg <= 1'b1;
          bitcnt_reg <= '0;
          miso_reg   <= 1'b0;
        end
        default: miso_reg <= 1'b0;
      endcase

      if (frame_start) begin
        if (!trdy_reg) begin
          shift_tx_reg <= txdata_reg;
          trdy_reg     <= 1'b1;
          miso_reg     <= txdata_reg[DW-1];
        end else begin
          shift_tx_reg <= '0;
          toe_reg      <= 1'b1;
          miso_reg     <= 1'b0;
        end
      end
      // A txdata write lands last: the frame load above used the old word, and TRDY ends at 0.
      if (wr_en && mem_addr == 3'd1) begin
        txdata_reg <= data_from_cpu;
        trdy_reg   <= 1'b0;
      end

      irq_reg <= |({rrdy_reg, trdy_reg, tmt, toe_reg, roe_reg} & ctrl_reg[4:0])
                 | (ctrl_reg[5] & err_any);
    end
  end

  assign data_to_cpu      = data_out_reg;
  assign dataavailable    = rrdy_reg;
  assign readyfordata     = trdy_reg;
  assign transmitterempty = tmt;
  assign irq              = irq_reg;
  assign MISO             = miso_reg;
endmodule

// File: tb/tb_spi_slave_regs.sv
// Bench for spi_slave_regs: a bit-banged SPI master plus host bus tasks, with queued
// expectations checked by monitors on host read data and on every received MISO word.
module tb_spi_slave_regs;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset, read_n, write_n, spi_select, SCLK, MOSI, SS_n;
  logic [15:0] data_from_cpu;
  logic [2:0]  mem_addr;
  logic [15:0] data_to_cpu;
  logic        dataavailable, readyfordata, transmitterempty, irq, MISO;

  spi_slave_regs #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .data_from_cpu(data_from_cpu), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .spi_select(spi_select), .data_to_cpu(data_to_cpu),
    .dataavailable(dataavailable), .readyfordata(readyfordata),
    .transmitterempty(transmitterempty), .irq(irq), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
    .MISO(MISO)
  );

  always #5 clk = ~clk;

  int          checks = 0, failures = 0;
  int          cyc = 0, rrdy_rises = 0, rrdy_cyc = 0, irq_cyc = 0;
  logic [15:0] exp_rd_q[$];
  string       rd_name_q[$];
  logic [15:0] exp_miso_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    @(posedge clk); #1;
    spi_select = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    exp_rd_q.push_back(exp);
    rd_name_q.push_back(name);
    @(posedge clk); #1;
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    @(posedge clk); #1;
    spi_select = 1'b0; read_n = 1'b1;
  endtask

  // mid_op at bit 8: 1 = write txdata, 2 = read rxdata, 3 = pulse reset and check reset values
  task automatic spi_frame(input logic [15:0] mosi, input logic [15:0] miso_exp, input int nbits,
                           input bit keep_low, input int mid_op, input logic [15:0] mid_val);
    if (nbits == 16) exp_miso_q.push_back(miso_exp);
    SS_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi[15-i];
      wait_clk(HALF);
      SCLK = 1'b1;
      if (i == 8) begin
        case (mid_op)
          1: wr(3'd1, mid_val);
          2: rd(3'd0, mid_val, "rx_mid_frame");
          3: begin
            chk("irq_before_reset", {31'd0, irq}, 32'd1);
            chk("miso_before_reset", {31'd0, MISO}, 32'd1);
            reset = 1'b1;
            wait_clk(2);
            chk("rst_data_to_cpu", {16'd0, data_to_cpu}, 32'd0);
            chk("rst_miso", {31'd0, MISO}, 32'd0);
            chk("rst_rrdy", {31'd0, dataavailable}, 32'd0);
            chk("rst_trdy", {31'd0, readyfordata}, 32'd1);
            chk("rst_tmt", {31'd0, transmitterempty}, 32'd1);
            chk("rst_irq", {31'd0, irq}, 32'd0);
            reset = 1'b0;
          end
          default: ;
        endcase
      end
      if (i == 15 && !keep_low) begin
        wait_clk(2);
        SS_n = 1'b1;
        wait_clk(HALF - 2);
      end else begin
        wait_clk(HALF);
      end
      SCLK = 1'b0;
    end
    if (!keep_low && nbits != 16) begin
      wait_clk(HALF);
      SS_n = 1'b1;
    end
    MOSI = 1'b0;
    wait_clk(HALF);
  endtask

  // Host-side monitor: compares data_to_cpu after every read strobe, tracks RRDY/irq rises.
  initial begin
    logic fire, da_prev, irq_prev;
    da_prev = 1'b0; irq_prev = 1'b0;
    forever begin
      @(posedge clk);
      fire = spi_select && !read_n && !reset;
      #1;
      cyc++;
      if (fire) begin
        if (exp_rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_read actual=%h required=none", data_to_cpu);
        end else begin
          chk(rd_name_q.pop_front(), {16'd0, data_to_cpu}, {16'd0, exp_rd_q.pop_front()});
        end
      end
      if (dataavailable === 1'b1 && da_prev === 1'b0) begin rrdy_rises++; rrdy_cyc = cyc; end
      if (irq === 1'b1 && irq_prev === 1'b0) irq_cyc = cyc;
      da_prev = dataavailable; irq_prev = irq;
    end
  end

  // SPI-side monitor: assembles MISO on rising SCLK; an SS_n rise discards a partial word.
  initial begin
    int n;
    logic [15:0] w;
    n = 0; w = '0;
    forever begin
      @(posedge SCLK or posedge SS_n);
      if (SS_n) begin
        n = 0;
      end else begin
        w = {w[14:0], MISO};
        n++;
        if (n == 16) begin
          n = 0;
          if (exp_miso_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_miso_word actual=%h required=none", w);
          end else begin
            chk("miso_word", {16'd0, w}, {16'd0, exp_miso_q.pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1; mem_addr = '0; data_from_cpu = '0;
    wait_clk(5);
    chk("reset_data_to_cpu", {16'd0, data_to_cpu}, 32'd0);
    chk("reset_rrdy", {31'd0, dataavailable}, 32'd0);
    chk("reset_trdy", {31'd0, readyfordata}, 32'd1);
    chk("reset_tmt", {31'd0, transmitterempty}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    chk("reset_miso", {31'd0, MISO}, 32'd0);
    reset = 1'b0;
    wait_clk(2);
    rd(3'd2, 16'h0060, "status_after_reset");

    // Basic frame
    wr(3'd1, 16'hA55A);
    rd(3'd1, 16'hA55A, "txdata_readback");
    rd(3'd2, 16'h0000, "status_tx_loaded");
    spi_frame(16'h3C96, 16'hA55A, 16, 1'b0, 0, 16'h0);
    rd(3'd2, 16'h00E0, "status_frame1");
    rd(3'd0, 16'h3C96, "rx_frame1");
    rd(3'd2, 16'h0060, "status_after_rx_read");

    // Overrun
    wr(3'd1, 16'h1234);
    spi_frame(16'hBEEF, 16'h1234, 16, 1'b0, 0, 16'h0);
    wr(3'd1, 16'h5678);
    spi_frame(16'hCAFE, 16'h5678, 16, 1'b0, 0, 16'h0);
    rd(3'd2, 16'h01E8, "status_overrun");
    rd(3'd0, 16'hCAFE, "rx_overrun_second");
    wr(3'd2, 16'h0000);
    rd(3'd2, 16'h0060, "status_roe_cleared");

    // Underrun
    spi_frame(16'h5AA5, 16'h0000, 16, 1'b0, 0, 16'h0);
    rd(3'd2, 16'h01F0, "status_underrun");
    rd(3'd0, 16'h5AA5, "rx_underrun");
    wr(3'd2, 16'h0000);
    rd(3'd2, 16'h0060, "status_toe_cleared");

    // Aborted partial frame, then a clean frame
    wr(3'd1, 16'hFFFF);
    spi_frame(16'h0123, 16'h0000, 7, 1'b0, 0, 16'h0);
    rd(3'd2, 16'h0060, "status_after_abort");
    rd(3'd0, 16'h5AA5, "rx_untouched_by_abort");
    wr(3'd1, 16'h0F0F);
    spi_frame(16'h0001, 16'h0F0F, 16, 1'b0, 0, 16'h0);
    rd(3'd2, 16'h00E0, "status_after_abort_frame");
    rd(3'd0, 16'h0001, "rx_after_abort");

    // Back-to-back frames with SS_n held low
    rrdy_rises = 0;
    wr(3'd1, 16'h1111);
    spi_frame(16'hAAAA, 16'h1111, 16, 1'b1, 1, 16'h2222);
    spi_frame(16'h5555, 16'h2222, 16, 1'b0, 2, 16'hAAAA);
    chk("b2b_rrdy_events", rrdy_rises, 32'd2);
    rd(3'd0, 16'h5555, "rx_b2b_second");
    rd(3'd2, 16'h0060, "status_b2b");

    // Interrupt on RRDY, then reset mid-frame, then a frame after resync
    wr(3'd3, 16'h0080);
    wr(3'd1, 16'h00FF);
    spi_frame(16'h1357, 16'h00FF, 16, 1'b0, 0, 16'h0);
    chk("irq_latency_after_rrdy", irq_cyc - rrdy_cyc, 32'd1);
    chk("irq_set", {31'd0, irq}, 32'd1);
    rd(3'd0, 16'h1357, "rx_irq_frame");
    chk("irq_still_set_at_read", {31'd0, irq}, 32'd1);
    wait_clk(1);
    chk("irq_dropped", {31'd0, irq}, 32'd0);
    wr(3'd3, 16'h0040);
    wr(3'd1, 16'hFFFF);
    spi_frame(16'h0000, 16'h0000, 9, 1'b0, 3, 16'h0);
    wr(3'd1, 16'h8001);
    spi_frame(16'h0F0F, 16'h8001, 16, 1'b0, 0, 16'h0);
    rd(3'd0, 16'h0F0F, "rx_after_reset");
    rd(3'd2, 16'h0060, "status_final");

    wait_clk(4);
    chk("read_queue_drained", exp_rd_q.size(), 32'd0);
    chk("miso_queue_drained", exp_miso_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
